data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_byte_ram.sv | 34 +++
 rtl/data_memory_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
//   size_e      : access size encodings carried on req_size
//   state_e     : controller FSM states
//   LATENCY_MIN/LATENCY_MAX : legal range of the LATENCY parameter
package dmem_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH_WORDS x 32-bit storage with per-byte write enables and a registered read.
//   clk   : clock
//   en    : access enable; read and any enabled byte writes happen on this edge
//   we    : byte-lane write enables (bit i writes wdata[8*i+7:8*i])
//   addr  : word index
//   wdata : write data, already replicated onto the addressed lanes
//   rdata : word read on the last enabled edge (pre-write contents); held otherwise
// Contents are deliberately not reset.
module dmem_byte_ram #(
    parameter int unsigned DEPTH_WORDS = 64,
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding load/store controller in front of a byte-enabled word RAM.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid/rsp_ready  : response handshake, LATENCY cycles after acceptance
//   rsp_rdata, rsp_err   : extended load data (0 for stores/errors), fault flag
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // WAIT lasts LATENCY-1 edges; the counter holds the remaining extra edges.
    localparam logic [1:0] WAIT_INIT = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_memory_ctrl: LATENCY out of range");
    end

    state_e      state_q;
    logic [1:0]  wait_cnt_q;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    // The RAM access happens on the accepting edge when LATENCY = 1, otherwise on
    // the edge leaving WAIT; pick live or captured fields accordingly.
    logic        cur_we;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [3:0]  cur_be;
    logic [31:0] lane_wdata;
    logic        accept;
    logic        access;
    logic        ram_en;
    logic [31:0] ram_rdata;

    assign cur_we    = (state_q == StIdle) ? req_we    : cap_we;
    assign cur_size  = (state_q == StIdle) ? req_size  : cap_size;
    assign cur_addr  = (state_q == StIdle) ? req_addr  : cap_addr;
    assign cur_wdata = (state_q == StIdle) ? req_wdata : cap_wdata;

    assign accept = req_valid && req_ready && (state_q == StIdle);
    assign access = (accept && (LATENCY == 1)) || ((state_q == StWait) && (wait_cnt_q == 2'd0));

    always_comb begin
        cur_err    = 1'b0;
        cur_be     = 4'b0000;
        lane_wdata = cur_wdata;
        case (cur_size)
            SizeByte: begin
                cur_be     = 4'b0001 << cur_addr[1:0];
                lane_wdata = {4{cur_wdata[7:0]}};
            end
            SizeHalf: begin
                cur_err    = cur_addr[0];
                cur_be     = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cur_wdata[15:0]}};
            end
            SizeWord: begin
                cur_err = (cur_addr[1:0] != 2'b00);
                cur_be  = 4'b1111;
            end
            default: cur_err = 1'b1;
        endcase
        if ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS) begin
            cur_err = 1'b1;
        end
    end

    // Errored accesses never touch the RAM, so no errored store can write.
    assign ram_en = access && !cur_err;

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (cur_we ? cur_be : 4'b0000),
        .addr (cur_addr[AW+1:2]),
        .wdata(lane_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 2'd0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            cap_we       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= 32'd0;
            cap_wdata    <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!req_ready) begin
                        // First edge after reset release.
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        cap_we       <= req_we;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        req_ready    <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= cur_err;
                        end else begin
                            state_q    <= StWait;
                            wait_cnt_q <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cur_err;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Load extraction from the RAM read register, which only changes on access
    // edges and therefore stays stable throughout RESP.
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    always_comb begin
        lane_byte = ram_rdata[7:0];
        unique case (cap_addr[1:0])
            2'd0: lane_byte = ram_rdata[7:0];
            2'd1: lane_byte = ram_rdata[15:8];
            2'd2: lane_byte = ram_rdata[23:16];
            2'd3: lane_byte = ram_rdata[31:24];
        endcase
        lane_half = cap_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (cap_size)
            SizeByte: load_ext = {{24{!cap_unsigned && lane_byte[7]}}, lane_byte};
            SizeHalf: load_ext = {{16{!cap_unsigned && lane_half[15]}}, lane_half};
            default:  load_ext = ram_rdata;
        endcase
    end

    assign rsp_rdata = (rsp_valid && !rsp_err && !cap_we) ? load_ext : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: DUT a at LATENCY 1, DUT b at LATENCY 3, both DEPTH_WORDS 64.
module tb_data_memory_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic        req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;

    logic        sel;  // 0 -> DUT a, 1 -> DUT b
    logic        rdy, vld, err;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    assign rdy   = sel ? req_ready_b : req_ready_a;
    assign vld   = sel ? rsp_valid_b : rsp_valid_a;
    assign err   = sel ? rsp_err_b   : rsp_err_a;
    assign rdata = sel ? rsp_rdata_b : rsp_rdata_a;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    data_memory_ctrl #(.DEPTH_WORDS(64), .LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request and return #1 after its accepting edge with req_valid dropped.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        guard = 0;
        while (!rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy) check("accept_timeout", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    // Edges counted from (and including) the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!vld && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!vld) check("rsp_timeout", {31'd0, vld}, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int lat;
        issue(we, size, uns, addr, wdata);
        wait_rsp(lat);
        check({tag, "_data"}, rdata, exp_data);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (exp_lat != 0) check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk);  // handshake, rsp_ready is high
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, resp_cnt, vcount;
        logic [31:0] b2b_data;
        logic        b2b_err;
        rst_n = 1'b0; sel = 1'b0; rsp_ready = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_size = W; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready_a}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata_a, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_req_ready_a", {31'd0, req_ready_a}, 32'd1);
        check("rel_req_ready_b", {31'd0, req_ready_b}, 32'd1);

        // LATENCY 1: word, byte and half accesses
        do_req("sw8",  1'b1, W, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        do_req("lw8",  1'b0, W, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        do_req("sb9",  1'b1, B, 1'b0, 32'h9, 32'hAABBCC55, 32'h0, 1'b0, 0);
        do_req("lw8b", 1'b0, W, 1'b0, 32'h8, 32'h0, 32'hDEAD55EF, 1'b0, 0);
        do_req("lb9",  1'b0, B, 1'b0, 32'h9, 32'h0, 32'h00000055, 1'b0, 0);
        do_req("lbuB", 1'b0, B, 1'b1, 32'hB, 32'h0, 32'h000000DE, 1'b0, 0);
        do_req("lbB",  1'b0, B, 1'b0, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
        do_req("lhA",  1'b0, H, 1'b0, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
        do_req("lhu8", 1'b0, H, 1'b1, 32'h8, 32'h0, 32'h000055EF, 1'b0, 0);

        // Faults
        do_req("lh3",    1'b0, H, 1'b0, 32'h3,   32'h0, 32'h0, 1'b1, 0);
        do_req("sw0",    1'b1, W, 1'b0, 32'h0,   32'h01020304, 32'h0, 1'b0, 0);
        do_req("sw102",  1'b1, W, 1'b0, 32'h102, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req("sw100",  1'b1, W, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req("lw100",  1'b0, W, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0);
        do_req("sh1",    1'b1, H, 1'b0, 32'h1,   32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req("lsz3",   1'b0, X, 1'b0, 32'h0,   32'h0, 32'h0, 1'b1, 0);
        do_req("lw0",    1'b0, W, 1'b0, 32'h0,   32'h0, 32'h01020304, 1'b0, 0);
        do_req("sb3",    1'b1, B, 1'b0, 32'h3,   32'h00000099, 32'h0, 1'b0, 0);
        do_req("lw0b",   1'b0, W, 1'b0, 32'h0,   32'h0, 32'h99020304, 1'b0, 0);

        // Back-to-back sh 0x6 then lhu 0x6 with req_valid held high
        resp_cnt = 0; b2b_data = '0; b2b_err = 1'b1;
        @(negedge clk);
        req_we = 1'b1; req_size = H; req_unsigned = 1'b0; req_addr = 32'h6; req_wdata = 32'h1234BEEF;
        req_valid_a = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid_a && rsp_ready) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    check("b2b_sh_err", {31'd0, rsp_err_a}, 32'd0);
                    req_we = 1'b0; req_unsigned = 1'b1;
                end else begin
                    b2b_data = rsp_rdata_a;
                    b2b_err  = rsp_err_a;
                    req_valid_a = 1'b0;
                end
            end
        end
        req_valid_a = 1'b0;
        check("b2b_count", resp_cnt, 2);
        check("b2b_lhu_data", b2b_data, 32'h0000BEEF);
        check("b2b_lhu_err", {31'd0, b2b_err}, 32'd0);

        // LATENCY 3
        sel = 1'b1;
        do_req("L3_sw20", 1'b1, W, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 3);
        do_req("L3_lw20", 1'b0, W, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 3);

        // Response held under backpressure
        rsp_ready = 1'b0;
        issue(1'b0, W, 1'b0, 32'h20, 32'h0);
        wait_rsp(lat);
        check("stall_lat", lat, 3);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, vld}, 32'd1);
            check("stall_rdata", rdata, 32'hCAFEF00D);
            check("stall_err",   {31'd0, err}, 32'd0);
            check("stall_ready", {31'd0, rdy}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done_valid", {31'd0, vld}, 32'd0);
        check("stall_done_ready", {31'd0, rdy}, 32'd1);

        // Reset while a store is in flight
        do_req("L3_sw10", 1'b1, W, 1'b0, 32'h10, 32'h11111111, 32'h0, 1'b0, 3);
        issue(1'b1, W, 1'b0, 32'h10, 32'h12345678);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, vld}, 32'd0);
        check("midrst_ready", {31'd0, rdy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcount = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (vld) vcount++;
        end
        check("midrst_no_rsp", vcount, 0);
        do_req("L3_lw10", 1'b0, W, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
